float_accum_seq: RTL and testbench

Sequencer for the float accumulator unit. It latches a job configuration and drives the unit's run/running/strideMinusOne/delay0 controls. It mirrors the unit's internal window timing and emits a one-cycle strobe, with an index, in the exact cycle each accumulated float result is valid on the unit's output. It sits between the layer control registers and one accumulator instance.

---
 rtl/float_accum_seq.sv | 167 ++++++++++++++++
 tb/tb_float_accum_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/float_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : float_accum_seq
//  Purpose  : Job sequencer for one float accumulator instance. Latches a job
//             configuration, drives the accumulator run/running/stride/delay
//             controls and emits a one-cycle indexed strobe in the exact
//             cycle each window result is valid on the accumulator output.
//  Revision : 1.0  initial release
// ============================================================================
module float_accum_seq #(
    parameter int STRIDE_W = 16,
    parameter int DELAY_W  = 7,
    parameter int CNT_W    = 16,
    parameter int RES_LAT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [STRIDE_W-1:0] i_cfg_stride,
    input  logic [DELAY_W-1:0]  i_cfg_delay,
    input  logic [CNT_W-1:0]    i_cfg_windows,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_acc_run,
    output logic                o_acc_running,
    output logic [STRIDE_W-1:0] o_acc_stride_minus_one,
    output logic [DELAY_W-1:0]  o_acc_delay0,
    output logic                o_res_valid,
    output logic [CNT_W-1:0]    o_res_index,
    output logic                o_res_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACCUM = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    logic [STRIDE_W-1:0] r_cfg_stride;
    logic [DELAY_W-1:0]  r_cfg_delay;
    logic [CNT_W-1:0]    r_cfg_windows;
    logic [DELAY_W-1:0]  r_dcnt;      // cycles spent in WAIT since R
    logic [STRIDE_W-1:0] r_scnt;      // sample position inside current window
    logic [CNT_W-1:0]    r_wcnt;      // window currently being accumulated
    logic [CNT_W-1:0]    r_ridx;      // index of the next result strobe
    logic [RES_LAT-1:0]  r_pipe;      // one marker per closed window, in flight
    logic                r_busy;
    logic                r_run;
    logic                r_done0;     // completion pulse of an empty job

    logic                w_last;
    logic                w_res_valid;
    logic                w_res_last;
    logic                w_final;
    logic [RES_LAT-1:0]  w_pipe_next;

    // Window-close detection, result strobe decode and marker pipe shift
    always_comb begin
        w_last      = (r_state == S_ACCUM) && (r_scnt == r_cfg_stride);
        w_res_valid = r_pipe[RES_LAT-1];
        w_res_last  = w_res_valid && (r_ridx == (r_cfg_windows - CNT_W'(1)));
        w_final     = w_res_last && r_busy;
        w_pipe_next = r_pipe << 1;
        w_pipe_next[0] = w_last;
    end

    // Job state machine, counters and registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cfg_stride  <= '0;
            r_cfg_delay   <= '0;
            r_cfg_windows <= '0;
            r_dcnt        <= '0;
            r_scnt        <= '0;
            r_wcnt        <= '0;
            r_ridx        <= '0;
            r_pipe        <= '0;
            r_busy        <= 1'b0;
            r_run         <= 1'b0;
            r_done0       <= 1'b0;
        end else begin
            r_run   <= 1'b0;
            r_done0 <= 1'b0;
            if (r_state == S_IDLE) begin
                if (i_start) begin
                    r_cfg_stride  <= i_cfg_stride;
                    r_cfg_delay   <= i_cfg_delay;
                    r_cfg_windows <= i_cfg_windows;
                    if (i_cfg_windows == '0) begin
                        r_done0 <= 1'b1;
                    end else begin
                        r_run   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                        r_dcnt  <= '0;
                        r_scnt  <= '0;
                        r_wcnt  <= '0;
                        r_ridx  <= '0;
                        r_pipe  <= '0;
                    end
                end
            end else if (i_abort) begin
                // Cancel: discard in-flight results, no completion pulse
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_pipe  <= '0;
                r_ridx  <= '0;
            end else begin
                r_pipe <= w_pipe_next;
                if (w_res_valid) begin
                    r_ridx <= r_ridx + CNT_W'(1);
                end
                case (r_state)
                    S_WAIT: begin
                        if (r_dcnt == r_cfg_delay) begin
                            r_state <= S_ACCUM;
                            r_scnt  <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + DELAY_W'(1);
                        end
                    end
                    S_ACCUM: begin
                        if (w_last) begin
                            r_scnt <= '0;
                            if (r_wcnt == (r_cfg_windows - CNT_W'(1))) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_wcnt <= r_wcnt + CNT_W'(1);
                            end
                        end else begin
                            r_scnt <= r_scnt + STRIDE_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (w_final) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_pipe  <= '0;
                            r_ridx  <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy                 = r_busy;
    assign o_acc_running          = r_busy;
    assign o_acc_run              = r_run;
    assign o_acc_stride_minus_one = r_cfg_stride;
    assign o_acc_delay0           = r_cfg_delay;
    assign o_res_valid            = w_res_valid;
    assign o_res_index            = w_res_valid ? r_ridx : '0;
    assign o_res_last             = w_res_last;
    // An abort in the final strobe cycle still shows the result but not done
    assign o_done                 = r_done0 | (w_final & ~i_abort);

endmodule
`default_nettype wire

// File: tb/tb_float_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float_accum_seq
//  Purpose  : Self-checking bench for float_accum_seq. A cycle-level job model
//             predicts result/done cycles into queues; a negedge monitor pops
//             and compares against what the design presents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_float_accum_seq;

    localparam int STRIDE_W = 16;
    localparam int DELAY_W  = 7;
    localparam int CNT_W    = 16;
    localparam int RES_LAT  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_start;
    logic                i_abort;
    logic [STRIDE_W-1:0] i_cfg_stride;
    logic [DELAY_W-1:0]  i_cfg_delay;
    logic [CNT_W-1:0]    i_cfg_windows;
    logic                o_busy;
    logic                o_done;
    logic                o_acc_run;
    logic                o_acc_running;
    logic [STRIDE_W-1:0] o_acc_stride_minus_one;
    logic [DELAY_W-1:0]  o_acc_delay0;
    logic                o_res_valid;
    logic [CNT_W-1:0]    o_res_index;
    logic                o_res_last;

    float_accum_seq #(
        .STRIDE_W (STRIDE_W),
        .DELAY_W  (DELAY_W),
        .CNT_W    (CNT_W),
        .RES_LAT  (RES_LAT)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_start                (i_start),
        .i_abort                (i_abort),
        .i_cfg_stride           (i_cfg_stride),
        .i_cfg_delay            (i_cfg_delay),
        .i_cfg_windows          (i_cfg_windows),
        .o_busy                 (o_busy),
        .o_done                 (o_done),
        .o_acc_run              (o_acc_run),
        .o_acc_running          (o_acc_running),
        .o_acc_stride_minus_one (o_acc_stride_minus_one),
        .o_acc_delay0           (o_acc_delay0),
        .o_res_valid            (o_res_valid),
        .o_res_index            (o_res_index),
        .o_res_last             (o_res_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        int idx;
        bit last;
    } res_t;

    res_t rq[$];
    int   dq[$];
    int   exp_lo = -1;      // cycle R of the current job
    int   exp_hi = -2;      // last busy cycle of the current job
    int   m_stride = 0;
    int   m_delay  = 0;
    bit   pend = 1'b0;
    int   p_stride, p_delay;

    task automatic model_step(input int c, input bit r, input bit s, input bit a,
                              input int st, input int dl, input int nw);
        bit busy_now;
        if (pend) begin
            m_stride = p_stride;
            m_delay  = p_delay;
            pend     = 1'b0;
        end
        if (r) begin
            for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].cyc >= c) rq.delete(i);
            for (int i = dq.size() - 1; i >= 0; i--) if (dq[i] >= c) dq.delete(i);
            if (exp_hi >= c) exp_hi = c - 1;
            m_stride = 0;
            m_delay  = 0;
            return;
        end
        busy_now = (c >= exp_lo) && (c <= exp_hi);
        if (busy_now) begin
            if (a) begin
                exp_hi = c;
                for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].cyc > c) rq.delete(i);
                for (int i = dq.size() - 1; i >= 0; i--) if (dq[i] >= c) dq.delete(i);
            end
        end else if (s) begin
            pend     = 1'b1;
            p_stride = st;
            p_delay  = dl;
            if (nw == 0) begin
                dq.push_back(c + 1);
            end else begin
                int rr, s0, fin;
                rr = c + 1;
                s0 = rr + 1 + dl;
                fin = 0;
                for (int w = 0; w < nw; w++) begin
                    res_t e;
                    e.cyc  = s0 + w * (st + 1) + st + RES_LAT;
                    e.idx  = w;
                    e.last = (w == nw - 1);
                    rq.push_back(e);
                    fin = e.cyc;
                end
                exp_lo = rr;
                exp_hi = fin;
                dq.push_back(fin);
            end
        end
    endtask

    // ---------------- monitor ----------------
    bit mon_busy;
    bit exp_v;
    bit exp_d;
    always @(negedge clk) begin
        mon_busy = (cyc >= exp_lo) && (cyc <= exp_hi);
        chk("ctrl", {o_busy, o_acc_running, o_acc_run, o_acc_stride_minus_one, o_acc_delay0},
            {mon_busy, mon_busy, mon_busy && (cyc == exp_lo), STRIDE_W'(m_stride), DELAY_W'(m_delay)});

        while (rq.size() > 0 && rq[0].cyc < cyc) void'(rq.pop_front());
        exp_v = (rq.size() > 0) && (rq[0].cyc == cyc);
        chk("res_valid", o_res_valid, exp_v);
        if (o_res_valid && rq.size() > 0) begin
            res_t e;
            e = rq.pop_front();
            chk("res_cycle", cyc, e.cyc);
            chk("res_index", o_res_index, e.idx);
            chk("res_last", o_res_last, e.last);
        end else if (!o_res_valid) begin
            chk("res_idle_zero", {o_res_index, o_res_last}, '0);
        end

        while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
        exp_d = (dq.size() > 0) && (dq[0] == cyc);
        chk("done", o_done, exp_d);
        if (exp_d) void'(dq.pop_front());
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit s, input bit a,
                         input int st, input int dl, input int nw);
        rst           = r;
        i_start       = s;
        i_abort       = a;
        i_cfg_stride  = STRIDE_W'(st);
        i_cfg_delay   = DELAY_W'(dl);
        i_cfg_windows = CNT_W'(nw);
        model_step(cyc, r, s, a, st, dl, nw);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_cfg_stride = '0; i_cfg_delay = '0; i_cfg_windows = '0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(3);

        // Basic job: stride 3, delay 2, two windows
        drive(1'b0, 1'b1, 1'b0, 3, 2, 2);
        idle(20);
        // Single-sample windows, back-to-back strobes
        drive(1'b0, 1'b1, 1'b0, 0, 0, 3);
        idle(12);
        // Empty job
        drive(1'b0, 1'b1, 1'b0, 5, 5, 0);
        idle(5);
        // Abort at relative cycle 9
        drive(1'b0, 1'b1, 1'b0, 3, 2, 2);
        idle(8);
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle(10);
        // Start while busy at relative cycle 5 is ignored
        drive(1'b0, 1'b1, 1'b0, 3, 2, 2);
        idle(4);
        drive(1'b0, 1'b1, 1'b0, 7, 1, 5);
        idle(15);
        // Reset mid-job, then a fresh job
        drive(1'b0, 1'b1, 1'b0, 3, 2, 2);
        idle(7);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 3, 2, 2);
        idle(20);
        // Abort in IDLE, start+abort together in IDLE
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 1, 0, 2);
        idle(15);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, s, a;
            int st, dl, nw;
            r  = ($urandom_range(0, 399) == 0);
            s  = ($urandom_range(0, 5) == 0);
            a  = ($urandom_range(0, 79) == 0);
            st = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
            dl = ($urandom_range(0, 19) == 0) ? 127 : $urandom_range(0, 5);
            nw = $urandom_range(0, 5);
            drive(r, s, a, st, dl, nw);
        end
        idle(400);

        chk("res_queue_empty", rq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
